// File: rtl/mc_ctrl_if.sv
// Control bus between the multicycle MIPS controller (master) and its datapath (slave).
// Optional Illegal flag exists only when MC_CTRL_ILLEGAL_TRAP_EN is defined.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic             Zero;
  logic             PCWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic             EXTOp;
  logic             ALUSrcB;
  logic             RegDst;
  logic             WDSel;
  logic [1:0]       NPCOp;
  logic [2:0]       ALUOp;
  logic [2:0]       State;
  logic             InstrDone;
  logic [CNT_W-1:0] Retired;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic             Illegal;
`endif

  modport master (
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    output Illegal,
`endif
    input  Op, Funct, Zero,
    output PCWrite, IRWrite, RegWrite, MemWrite, EXTOp, ALUSrcB, RegDst, WDSel,
    output NPCOp, ALUOp, State, InstrDone, Retired
  );

  modport slave (
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    input  Illegal,
`endif
    output Op, Funct, Zero,
    input  PCWrite, IRWrite, RegWrite, MemWrite, EXTOp, ALUSrcB, RegDst, WDSel,
    input  NPCOp, ALUOp, State, InstrDone, Retired
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM (IF/ID/EXE/MEM/WB) with retired-instruction counter.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap unsupported opcodes instead of treating them as NOPs.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input logic      clk,
  input logic      rst,
  mc_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , S_TRAP = 3'd7
`endif
  } state_t;

  typedef struct packed {
    logic rtype;
    logic addi;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d = '0;
    case (op)
      6'h00: d.rtype = fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};
      6'h08: d.addi  = 1'b1;
      6'h0D: d.ori   = 1'b1;
      6'h0F: d.lui   = 1'b1;
      6'h23: d.lw    = 1'b1;
      6'h2B: d.sw    = 1'b1;
      6'h04: d.beq   = 1'b1;
      6'h02: d.j     = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       funct_q, funct_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  dec_t dec_live, dec_lat;
  logic pcw, irw, rw, mw, ext, srcb, rdst, wd, done, illegal;
  logic [1:0] npc;
  logic [2:0] alu;

  assign dec_live = decode(bus.Op, bus.Funct);
  assign dec_lat  = decode(op_q, funct_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    funct_d = funct_q;
    pcw = 1'b0; irw = 1'b0; rw = 1'b0; mw = 1'b0;
    ext = 1'b0; srcb = 1'b0; rdst = 1'b0; wd = 1'b0;
    done = 1'b0; illegal = 1'b0;
    npc = 2'd0;
    alu = 3'd0;

    // ALU setup is held from EXE until the instruction retires.
    if (state_q inside {S_EXE, S_MEM, S_WB}) begin
      ext  = dec_lat.addi | dec_lat.lw | dec_lat.sw | dec_lat.beq;
      srcb = dec_lat.addi | dec_lat.ori | dec_lat.lui | dec_lat.lw | dec_lat.sw;
      if (dec_lat.rtype) begin
        case (funct_q)
          6'h23:   alu = 3'd1;
          6'h24:   alu = 3'd2;
          6'h25:   alu = 3'd3;
          6'h2A:   alu = 3'd4;
          default: alu = 3'd0;
        endcase
      end else if (dec_lat.ori) alu = 3'd3;
      else if (dec_lat.lui)     alu = 3'd5;
      else if (dec_lat.beq)     alu = 3'd1;
      else                      alu = 3'd0;
    end

    case (state_q)
      S_IF: begin
        irw     = 1'b1;
        pcw     = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        op_d    = bus.Op;
        funct_d = bus.Funct;
        if (dec_live.j) begin
          pcw     = 1'b1;
          npc     = 2'd2;
          done    = 1'b1;
          state_d = S_IF;
        end else if (|dec_live) begin
          state_d = S_EXE;
        end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          done    = 1'b1;
          state_d = S_IF;
`endif
        end
      end
      S_EXE: begin
        if (dec_lat.beq) begin
          npc     = 2'd1;
          pcw     = bus.Zero;
          done    = 1'b1;
          state_d = S_IF;
        end else if (dec_lat.lw | dec_lat.sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dec_lat.sw) begin
          mw      = 1'b1;
          done    = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        rw      = 1'b1;
        rdst    = dec_lat.rtype;
        wd      = dec_lat.lw;
        done    = 1'b1;
        state_d = S_IF;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: illegal = 1'b1;
`endif
      default: state_d = S_IF;
    endcase

    // Reset forces every strobe low so no partial write escapes while rst is high.
    if (rst) begin
      pcw = 1'b0; irw = 1'b0; rw = 1'b0; mw = 1'b0;
      ext = 1'b0; srcb = 1'b0; rdst = 1'b0; wd = 1'b0;
      done = 1'b0; illegal = 1'b0;
      npc = 2'd0;
      alu = 3'd0;
    end

    retired_d = retired_q + {{(CNT_W-1){1'b0}}, done};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      op_q      <= '0;
      funct_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      retired_q <= retired_d;
    end
  end

  assign bus.PCWrite   = pcw;
  assign bus.IRWrite   = irw;
  assign bus.RegWrite  = rw;
  assign bus.MemWrite  = mw;
  assign bus.EXTOp     = ext;
  assign bus.ALUSrcB   = srcb;
  assign bus.RegDst    = rdst;
  assign bus.WDSel     = wd;
  assign bus.NPCOp     = npc;
  assign bus.ALUOp     = alu;
  assign bus.State     = state_q;
  assign bus.InstrDone = done;
  assign bus.Retired   = retired_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign bus.Illegal   = illegal;
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle MIPS control unit: Moore/Mealy FSM that sequences PC, IR, register file, ALU, data memory and the immediate-extension unit through IF/ID/EXE/MEM/WB.
- Drives EXTOp to the extension unit: 1 = signed (`EXT_SIGNED`), 0 = zero-extend.
- Sits between the instruction register (Op/Funct), the ALU Zero flag and all datapath write-enables/muxes.
- Also counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- Op  input  6  IR[31:26]
- Funct  input  6  IR[5:0]
- Zero  input  1  ALU zero flag
- PCWrite  output  1  PC register enable
- IRWrite  output  1  IR enable
- RegWrite  output  1  register-file write enable
- MemWrite  output  1  data-memory write enable
- EXTOp  output  1  1 signed, 0 zero extension
- ALUSrcB  output  1  0 rt data, 1 Imm32
- RegDst  output  1  0 rt, 1 rd
- WDSel  output  1  0 ALU result, 1 memory data
- NPCOp  output  2  0 PC+4, 1 branch target, 2 jump target
- ALUOp  output  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LUI
- State  output  3  current state (debug)
- InstrDone  output  1  1-cycle pulse in final state of each instruction
- Retired  output  CNT_W  retired-instruction count

Behaviour:
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4.
- Reset (async, rst=1): State=IF, opcode/funct latches=0, Retired=0, all outputs 0.
- First rising edge after rst falls performs IF.
- Supported instructions (Op/Funct hex):
  - addu 00/21, subu 00/23, and 00/24, or 00/25, slt 00/2A
  - addi 08, ori 0D, lui 0F
  - lw 23, sw 2B, beq 04, j 02
- IF: IRWrite=1, PCWrite=1, NPCOp=0. Next state ID.
- ID: latch Op/Funct into internal registers. All later decode uses the latched copy; Op/Funct changes after ID are ignored.
  - j: PCWrite=1, NPCOp=2, InstrDone=1, next IF (2 cycles total).
  - Otherwise next EXE.
- EXE: ALUSrcB=1 for I-type; EXTOp=1 for addi/lw/sw/beq, 0 for ori/lui.
  - R-type and I-ALU: next WB.
  - lw/sw: ALUOp=ADD, next MEM.
  - beq: ALUOp=SUB, NPCOp=1, PCWrite=Zero (Mealy, same cycle), InstrDone=1, next IF (3 cycles total).
- MEM:
  - sw: MemWrite=1, InstrDone=1, next IF (4 cycles).
  - lw: next WB.
- WB: RegWrite=1, next IF.
  - R-type: RegDst=1, WDSel=0 (4 cycles).
  - I-ALU: RegDst=0, WDSel=0 (4 cycles).
  - lw: RegDst=0, WDSel=1 (5 cycles).
  - InstrDone=1 in all WB cases.
- EXTOp, ALUSrcB and ALUOp stay held through MEM/WB for the current instruction; all are 0 in IF/ID.
- Retired increments on each cycle with InstrDone=1; wraps from all-ones to 0.
- rst asserted mid-instruction: immediate return to IF. No partial write-enable is asserted after the rst edge; Retired clears.
- Unsupported Op, or Op=00 with an unlisted Funct: handled per the optional feature below.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: unsupported instruction in ID moves to TRAP state (State=7). In TRAP all enables are 0 and InstrDone=0; the FSM stays there until rst. An extra output Illegal (1 bit) is 1 in TRAP, 0 otherwise.
- Undefined: unsupported instruction behaves as a NOP. ID asserts InstrDone=1 and goes to IF, no writes; Retired still increments. The Illegal port does not exist.

Test Plan:
- Reset then addu (Op=00, Funct=21) → States 0,1,2,4,0. RegWrite=1 and RegDst=1 only in cycle 4; Retired=1.
- ori (Op=0D) → EXTOp=0, ALUSrcB=1, ALUOp=3 in EXE. addi (Op=08) → EXTOp=1, ALUOp=0.
- lw (Op=23) → 5 cycles, MEM then WB with WDSel=1, RegWrite=1. sw (Op=2B) → MemWrite=1 in MEM only, 4 cycles.
- beq (Op=04): Zero=1 → PCWrite=1, NPCOp=1 in EXE. Zero=0 → PCWrite=0. Both cases take 3 cycles.
- j (Op=02) → PCWrite=1, NPCOp=2 in ID. Changing Op to 23 during EXE of an addi has no effect on decode.
- rst pulsed during MEM of sw → MemWrite never asserts, State=0, Retired=0. Op=3F with the macro defined → State=7 and Illegal=1 until rst; without the macro → 2-cycle NOP, Retired +1.
